// File: rtl/cpu_run_ctl.sv
// cpu_run_ctl: run controller for the 8-bit stack CPU.
// Downloads code from the host link, then sequences CPU reset and clock-enable.
module cpu_run_ctl #(
  parameter int ADDR_WIDTH   = 12,
  parameter int MAX_LEN      = 512,
  parameter int RESET_CYCLES = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cmd_valid,
  input  logic [1:0]            cmd,
  output logic                  cmd_ready,
  input  logic                  stop_req,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_address,
  output logic [7:0]            wr_data,
  output logic                  cpu_reset,
  output logic                  cpu_clock_en,
  input  logic                  cpu_halt,
  output logic                  load_error,
  output logic [2:0]            state
);

  localparam int RW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [RW-1:0] RstLast = RW'(RESET_CYCLES - 1);
  localparam logic [12:0] MaxLen = 13'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_DATA   = 3'd3,
    S_RST    = 3'd4,
    S_RUN    = 3'd5,
    S_PAUSED = 3'd6,
    S_HALTED = 3'd7
  } state_e;

  state_e                state_q;
  logic [11:0]           len_q;
  logic [11:0]           cnt_q;
  logic [RW-1:0]         rcnt_q;
  logic                  tgt_run_q;
  logic                  step_q;
  logic                  wr_en_q;
  logic [ADDR_WIDTH-1:0] wr_address_q;
  logic [7:0]            wr_data_q;
  logic                  load_error_q;

  logic [11:0] cnt_d;
  logic [11:0] len_d;

  assign cnt_d = cnt_q + 12'd1;
  assign len_d = {len_q[11:8], rx_data};

  always_comb begin
    cmd_ready = (state_q == S_IDLE) || (state_q == S_PAUSED) ||
                (state_q == S_HALTED);
    rx_ready  = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                (state_q == S_DATA);
    cpu_reset = reset || (state_q == S_IDLE) || rx_ready ||
                (state_q == S_RST);
    // A pending step pulse only ever exists while PAUSED.
    cpu_clock_en = ((state_q == S_RUN) && !cpu_halt) || step_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      cnt_q        <= '0;
      rcnt_q       <= '0;
      tgt_run_q    <= 1'b0;
      step_q       <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_address_q <= '0;
      wr_data_q    <= '0;
      load_error_q <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      step_q  <= 1'b0;
      unique case (state_q)
        S_IDLE, S_HALTED: begin
          if (cmd_valid) begin
            unique case (cmd)
              2'd0: begin
                state_q      <= S_LEN_HI;
                load_error_q <= 1'b0;
              end
              2'd1, 2'd2: begin
                state_q   <= S_RST;
                rcnt_q    <= RstLast;
                tgt_run_q <= ~cmd[1];
              end
              default: ;
            endcase
          end
        end
        S_PAUSED: begin
          if (cmd_valid) begin
            unique case (cmd)
              2'd0: begin
                state_q      <= S_LEN_HI;
                load_error_q <= 1'b0;
              end
              2'd1: state_q <= S_RUN;
              2'd2: step_q  <= 1'b1;
              default: ;
            endcase
          end
        end
        S_LEN_HI: begin
          if (rx_valid) begin
            len_q[11:8] <= rx_data[3:0];
            state_q     <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (rx_valid) begin
            len_q   <= len_d;
            cnt_q   <= '0;
            state_q <= (len_d == 12'd0) ? S_IDLE : S_DATA;
          end
        end
        S_DATA: begin
          if (rx_valid) begin
            // Bytes past physical memory are swallowed to keep the host in sync.
            if ({1'b0, cnt_q} < MaxLen) begin
              wr_en_q      <= 1'b1;
              wr_address_q <= ADDR_WIDTH'(cnt_q);
              wr_data_q    <= rx_data;
            end else begin
              load_error_q <= 1'b1;
            end
            cnt_q <= cnt_d;
            if (cnt_d == len_q) state_q <= S_IDLE;
          end
        end
        S_RST: begin
          if (rcnt_q == '0) state_q <= tgt_run_q ? S_RUN : S_PAUSED;
          else rcnt_q <= rcnt_q - 1'b1;
        end
        S_RUN: begin
          if (cpu_halt) state_q <= S_HALTED;
          else if (stop_req) state_q <= S_PAUSED;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_address = wr_address_q;
  assign wr_data    = wr_data_q;
  assign load_error = load_error_q;
  assign state      = state_q;

endmodule
